// File: rtl/serv_lsu_seq.sv
// Load/store sequencer: one Wishbone classic cycle per request, then streams read data W bits/cycle LSB first.
// Latency: i_req->o_wb_cyc 1 cycle, ack->o_done (store) or first o_rd_valid (load) 1 cycle; optional ack timeout via SERV_LSU_TIMEOUT_EN.
// Backpressure: none; requests while busy or during the o_done cycle are dropped, BUS waits for i_wb_ack.
module serv_lsu_seq #(
    parameter int W       = 1,
    parameter int B       = W - 1,
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_adr,
    input  logic [31:0] i_dat,
    input  logic [3:0]  i_sel,
    input  logic        i_misalign,
    output logic        o_busy,
    output logic        o_rd_valid,
    output logic [B:0]  o_rd,
    output logic        o_done,
    output logic        o_trap,
    output logic        o_err,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack
);

    localparam int         BEATS    = 32 / W;
    localparam logic [5:0] LAST     = 6'(BEATS - 1);
    localparam logic [5:0] PRE_LAST = 6'(BEATS - 2);

    typedef enum logic [1:0] {IDLE, BUS, STREAM} state_t;

    state_t      state, next_state;
    logic [31:0] shreg;
    logic [5:0]  beat_cnt;
    logic        accept, trap_set, done_set, ld_cap;

`ifdef SERV_LSU_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        err_set;
`endif

    assign o_busy = (state != IDLE);
    assign o_rd   = shreg[B:0];

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        trap_set   = 1'b0;
        done_set   = 1'b0;
        ld_cap     = 1'b0;
`ifdef SERV_LSU_TIMEOUT_EN
        err_set    = 1'b0;
`endif
        case (state)
            IDLE: begin
                // o_done still high means the previous store is finishing this cycle
                if (i_req && !o_done) begin
                    if (i_misalign) begin
                        trap_set = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        next_state = BUS;
                    end
                end
            end
            BUS: begin
                if (o_wb_cyc && i_wb_ack) begin
                    if (o_wb_we) begin
                        done_set   = 1'b1;
                        next_state = IDLE;
                    end else begin
                        ld_cap     = 1'b1;
                        next_state = STREAM;
                    end
                end
`ifdef SERV_LSU_TIMEOUT_EN
                else if (to_cnt == 16'(TIMEOUT - 1)) begin
                    err_set    = 1'b1;
                    next_state = IDLE;
                end
`endif
            end
            STREAM: begin
                if (beat_cnt == PRE_LAST) done_set = 1'b1;
                if (beat_cnt == LAST) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            o_wb_cyc   <= 1'b0;
            o_wb_adr   <= 32'h0;
            o_wb_dat   <= 32'h0;
            o_wb_sel   <= 4'h0;
            o_wb_we    <= 1'b0;
            o_rd_valid <= 1'b0;
            o_done     <= 1'b0;
            o_trap     <= 1'b0;
            shreg      <= 32'h0;
            beat_cnt   <= 6'd0;
        end else begin
            state      <= next_state;
            o_done     <= done_set;
            o_trap     <= trap_set;
            o_rd_valid <= (next_state == STREAM);
            if (accept) begin
                o_wb_adr <= i_adr & 32'hFFFF_FFFC;
                o_wb_dat <= i_dat;
                o_wb_sel <= i_sel;
                o_wb_we  <= i_we;
                o_wb_cyc <= 1'b1;
            end else if (state == BUS && next_state != BUS) begin
                o_wb_cyc <= 1'b0;
            end
            if (ld_cap) begin
                shreg    <= i_wb_rdt;
                beat_cnt <= 6'd0;
            end else if (state == STREAM) begin
                shreg    <= shreg >> W;
                beat_cnt <= beat_cnt + 6'd1;
            end
        end
    end

`ifdef SERV_LSU_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            to_cnt <= 16'd0;
            o_err  <= 1'b0;
        end else begin
            o_err <= err_set;
            if (accept) to_cnt <= 16'd0;
            else if (state == BUS && !i_wb_ack) to_cnt <= to_cnt + 16'd1;
        end
    end
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_serv_lsu_seq.sv
// Drives identical requests into a W=1 and a W=4 sequencer and checks both against a beat-level reference.
module tb_serv_lsu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, mis, ack;
    logic [31:0] adr, dat, rdt;
    logic [3:0]  sel;

    logic        busy1, rdv1, done1, trap1, err1, cyc1, wwe1;
    logic [0:0]  rd1;
    logic [31:0] wadr1, wdat1;
    logic [3:0]  wsel1;
    logic        busy4, rdv4, done4, trap4, err4, cyc4, wwe4;
    logic [3:0]  rd4;
    logic [31:0] wadr4, wdat4;
    logic [3:0]  wsel4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serv_lsu_seq #(.W(1), .TIMEOUT(4)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_adr(adr), .i_dat(dat),
        .i_sel(sel), .i_misalign(mis), .o_busy(busy1), .o_rd_valid(rdv1), .o_rd(rd1),
        .o_done(done1), .o_trap(trap1), .o_err(err1), .o_wb_adr(wadr1), .o_wb_dat(wdat1),
        .o_wb_sel(wsel1), .o_wb_we(wwe1), .o_wb_cyc(cyc1), .i_wb_rdt(rdt), .i_wb_ack(ack));

    serv_lsu_seq #(.W(4), .TIMEOUT(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_adr(adr), .i_dat(dat),
        .i_sel(sel), .i_misalign(mis), .o_busy(busy4), .o_rd_valid(rdv4), .o_rd(rd4),
        .o_done(done4), .o_trap(trap4), .o_err(err4), .o_wb_adr(wadr4), .o_wb_dat(wdat4),
        .o_wb_sel(wsel4), .o_wb_we(wwe4), .o_wb_cyc(cyc4), .i_wb_rdt(rdt), .i_wb_ack(ack));

    // {cyc1,cyc4,busy1,busy4,done1,done4,rdv1,rdv4,trap1,trap4,err1,err4}
    wire [11:0] flags = {cyc1, cyc4, busy1, busy4, done1, done4, rdv1, rdv4, trap1, trap4, err1, err4};

    // Caller is at a negedge; the request is driven in this cycle. poke re-requests in the store o_done cycle.
    task automatic run_txn(input logic w_e, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] r, input int dly, input bit poke);
        logic [68:0] exp_bus;
        logic [11:0] exp_f;
        logic [31:0] sh;
        exp_bus = {a & 32'hFFFF_FFFC, d, s, w_e};
        req = 1'b1; we = w_e; adr = a; dat = d; sel = s; mis = 1'b0; rdt = $urandom;
        @(negedge clk);
        req = 1'b0; adr = $urandom; dat = $urandom; sel = 4'($urandom); we = ~w_e;
        for (int c = 0; c <= dly; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if (flags !== 12'b1111_0000_0000) begin
                errors++; $display("FAIL bus_flags c=%0d: got %b exp %b", c, flags, 12'b1111_0000_0000);
            end
            checks++;
            if ({wadr1, wdat1, wsel1, wwe1, wadr4, wdat4, wsel4, wwe4} !== {exp_bus, exp_bus}) begin
                errors++; $display("FAIL bus_regs c=%0d: got %h/%h exp %h", c,
                                   {wadr1, wdat1, wsel1, wwe1}, {wadr4, wdat4, wsel4, wwe4}, exp_bus);
            end
            if (c == dly) begin ack = 1'b1; rdt = r; end
        end
        @(negedge clk);
        ack = 1'b0; rdt = $urandom;
        if (w_e) begin
            checks++;
            if (flags !== 12'b0000_1100_0000) begin
                errors++; $display("FAIL store_done: got %b exp %b", flags, 12'b0000_1100_0000);
            end
            if (poke) begin
                req = 1'b1; we = 1'b1; mis = 1'b0; adr = $urandom; dat = $urandom; sel = 4'hF;
            end
            @(negedge clk);
            checks++;
            if (flags !== 12'b0) begin
                errors++; $display("FAIL store_after: got %b exp %b", flags, 12'b0);
            end
            req = 1'b0;
        end else begin
            for (int k = 0; k <= 32; k++) begin
                if (k > 0) @(negedge clk);
                exp_f = {2'b00, k < 32, k < 8, k == 31, k == 7, k < 32, k < 8, 4'b0000};
                checks++;
                if (flags !== exp_f) begin
                    errors++; $display("FAIL load_flags k=%0d: got %b exp %b", k, flags, exp_f);
                end
                if (k < 32) begin
                    checks++;
                    if (rd1 !== r[k]) begin
                        errors++; $display("FAIL w1_beat k=%0d: got %b exp %b", k, rd1, r[k]);
                    end
                end
                if (k < 8) begin
                    sh = r >> (4 * k);
                    checks++;
                    if (rd4 !== sh[3:0]) begin
                        errors++; $display("FAIL w4_beat k=%0d: got %h exp %h", k, rd4, sh[3:0]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; we = 1'b0; mis = 1'b0; ack = 1'b0;
        adr = 32'h0; dat = 32'h0; sel = 4'h0; rdt = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (flags !== 12'b0) begin errors++; $display("FAIL reset_flags: got %b exp 0", flags); end
        checks++;
        if ({wadr1, wdat1, wsel1, wwe1, rd1, wadr4, wdat4, wsel4, wwe4, rd4} !== 143'b0) begin
            errors++; $display("FAIL reset_regs: got %h exp 0",
                               {wadr1, wdat1, wsel1, wwe1, rd1, wadr4, wdat4, wsel4, wwe4, rd4});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store();
        run_txn(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 32'h0, 3, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_load();
        run_txn(1'b0, 32'h0000_2000, 32'h0, 4'hF, 32'h8000_0001, 0, 1'b0);
        @(negedge clk);
        run_txn(1'b0, 32'h0000_2003, 32'h0, 4'hF, 32'h7654_3210, 2, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_misalign();
        req = 1'b1; mis = 1'b1; we = 1'b0; adr = 32'h0000_3001;
        @(negedge clk);
        req = 1'b0; mis = 1'b0;
        checks++;
        if (flags !== 12'b0000_0000_1100) begin
            errors++; $display("FAIL trap_pulse: got %b exp %b", flags, 12'b0000_0000_1100);
        end
        ack = 1'b1;  // stray ack while idle
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ack = 1'b0;
            checks++;
            if (flags !== 12'b0) begin
                errors++; $display("FAIL trap_after c=%0d: got %b exp 0", c, flags);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, 32'h0000_4008, 32'h1234_5678, 4'h3, 32'h0, 0, 1'b1);
        run_txn(1'b1, 32'h0000_400C, 32'hCAFE_F00D, 4'hC, 32'h0, 1, 1'b0);
        run_txn(1'b0, 32'h0000_4010, 32'h0, 4'hF, 32'hA5C3_0F96, 0, 1'b0);
        run_txn(1'b1, 32'h0000_4014, 32'h0BAD_CAFE, 4'hF, 32'h0, 0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_reset_midop();
        req = 1'b1; we = 1'b0; mis = 1'b0; adr = 32'h0000_5000;
        @(negedge clk);
        req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (flags !== 12'b0) begin errors++; $display("FAIL rst_bus: got %b exp 0", flags); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req = 1'b1; we = 1'b0; adr = 32'h0000_5004;
        @(negedge clk);
        req = 1'b0; ack = 1'b1; rdt = 32'hFFFF_FFFF;
        @(negedge clk);
        ack = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({rdv1, rdv4} !== 2'b11) begin errors++; $display("FAIL rst_pre_beat5: got %b exp 11", {rdv1, rdv4}); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({flags, rd1, rd4} !== 17'b0) begin
            errors++; $display("FAIL rst_stream: got %b exp 0", {flags, rd1, rd4});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(1'b0, $urandom, 32'h0, 4'hF, $urandom, 1, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(1, 15)),
                    $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        @(negedge clk);
    endtask

`ifdef SERV_LSU_TIMEOUT_EN
    task automatic test_timeout();
        req = 1'b1; we = 1'b0; mis = 1'b0; adr = 32'h0000_6000;
        @(negedge clk);
        req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if (flags !== 12'b1111_0000_0000) begin
                errors++; $display("FAIL tmo_wait c=%0d: got %b exp %b", c, flags, 12'b1111_0000_0000);
            end
        end
        @(negedge clk);
        checks++;
        if (flags !== 12'b0000_0000_0011) begin
            errors++; $display("FAIL tmo_err: got %b exp %b", flags, 12'b0000_0000_0011);
        end
        @(negedge clk);
        checks++;
        if (flags !== 12'b0) begin errors++; $display("FAIL tmo_after: got %b exp 0", flags); end
        run_txn(1'b1, 32'h0000_6004, 32'h5555_AAAA, 4'hF, 32'h0, 3, 1'b0);
        run_txn(1'b0, 32'h0000_6008, 32'h0, 4'hF, 32'h1357_9BDF, 3, 1'b0);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store();
        test_load();
        test_misalign();
        test_back_to_back();
        test_reset_midop();
        test_random();
`ifdef SERV_LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
